// File: rtl/line_fifo_pkg.sv
// Shared constants for the pixel/line FIFO: default data path sizing, flag thresholds
// and the depth derivation used by the FIFO and its RAM.
package line_fifo_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_AF_THRESH  = 14;
    localparam int unsigned DEF_AE_THRESH  = 2;

    // Only power-of-two depths are supported, so depth follows directly from pointer width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/line_fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A read and write to the same address in one cycle returns the old word.
module line_fifo_dp_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [WIDTH-1:0]      w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [WIDTH-1:0]      r_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/line_fifo.sv
// Synchronous FIFO between GPU draw side and VGA scan-out: pointers, occupancy count,
// full/empty/almost flags, sticky error flags and synchronous flush around a dual-port RAM.
module line_fifo
    import line_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
    parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  w_ena,
    input  logic [WIDTH-1:0]      w_data,
    input  logic                  r_ena,
    output logic [WIDTH-1:0]      r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] w_ptr_q, r_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  r_valid_q, overflow_q, underflow_q;
    logic                  seen_q;
    logic                  rd_acc, wr_acc, ram_w_en, ram_r_en;
    logic [WIDTH-1:0]      ram_r_data;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign r_valid      = r_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc   = r_ena & ~empty;
    assign wr_acc   = w_ena & (~full | rd_acc);
    assign ram_w_en = wr_acc & ~rst & ~clear;
    assign ram_r_en = rd_acc & ~rst & ~clear;

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // The RAM read register has no reset; seen_q masks it to zero until the first pop
    // after rst. clear leaves seen_q alone so r_data holds across a flush.
    assign r_data = seen_q ? ram_r_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            seen_q      <= 1'b0;
        end else if (clear) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr_q <= w_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                r_ptr_q <= r_ptr_q + 1'b1;
                seen_q  <= 1'b1;
            end
            count_q   <= count_d;
            r_valid_q <= rd_acc;
            if (w_ena && full && !rd_acc) begin
                overflow_q <= 1'b1;
            end
            if (r_ena && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    line_fifo_dp_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .w_en   (ram_w_en),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_en   (ram_r_en),
        .r_addr (r_ptr_q),
        .r_data (ram_r_data)
    );

endmodule

// File: tb/tb_line_fifo.sv
// Self-checking bench for line_fifo: directed scenarios followed by randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_line_fifo;

    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          w_ena = 1'b0;
    logic [W-1:0]  w_data = '0;
    logic          r_ena = 1'b0;
    logic [W-1:0]  r_data;
    logic          r_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_rdata = '0;
    bit           m_rvalid = 0;
    bit           m_ovf = 0;
    bit           m_unf = 0;

    line_fifo #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .w_ena        (w_ena),
        .w_data       (w_data),
        .r_ena        (r_ena),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rs, input bit cl, input bit we, input logic [W-1:0] wd,
                              input bit re);
        bit was_full, was_empty, rd, wr;
        if (rs) begin
            q.delete();
            m_rdata  = '0;
            m_rvalid = 0;
            m_ovf    = 0;
            m_unf    = 0;
        end else if (cl) begin
            q.delete();
            m_rvalid = 0;
            m_ovf    = 0;
            m_unf    = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            rd = re && !was_empty;
            wr = we && (!was_full || rd);
            if (we && was_full && !rd) m_ovf = 1;
            if (re && was_empty) m_unf = 1;
            if (rd) m_rdata = q.pop_front();
            m_rvalid = rd;
            if (wr) q.push_back(wd);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check_eq("r_valid", 32'(r_valid), 32'(m_rvalid));
        check_eq("r_data", 32'(r_data), 32'(m_rdata));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare against the model.
    task automatic step(input bit rs, input bit cl, input bit we, input logic [W-1:0] wd,
                        input bit re);
        rst    = rs;
        clear  = cl;
        w_ena  = we;
        w_data = wd;
        r_ena  = re;
        @(posedge clk);
        model_edge(rs, cl, we, wd, re);
        #1;
        check_all();
    endtask

    task automatic fill_seq();
        for (int i = 1; i <= DEPTH; i++) step(0, 0, 1, W'(i), 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 1);
    endtask

    initial begin
        phase = "reset";
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        check_eq("rst_r_data", 32'(r_data), 32'h0);
        check_eq("rst_empty", 32'(empty), 32'h1);

        phase = "fill_drain";
        fill_seq();
        check_eq("full_after_16", 32'(full), 32'h1);
        check_eq("count_after_16", 32'(count), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 0, 0, '0, 1);
            check_eq("pop_order", 32'(r_data), 32'(i));
        end
        check_eq("empty_at_end", 32'(empty), 32'h1);

        phase = "overflow";
        fill_seq();
        step(0, 0, 1, 8'hAA, 0);
        check_eq("ovf_set", 32'(overflow), 32'h1);
        check_eq("ovf_count", 32'(count), 32'd16);
        drain(DEPTH);
        step(1, 0, 0, '0, 0);

        phase = "full_rw";
        fill_seq();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 8'h55, 1);
            check_eq("rw_data", 32'(r_data), (i < DEPTH) ? 32'(i + 1) : 32'h55);
        end
        check_eq("rw_no_ovf", 32'(overflow), 32'h0);
        drain(DEPTH);

        phase = "empty_rw";
        step(0, 0, 1, 8'h33, 1);
        check_eq("unf_set", 32'(underflow), 32'h1);
        check_eq("unf_rvalid", 32'(r_valid), 32'h0);
        check_eq("unf_count", 32'(count), 32'd1);
        step(0, 0, 0, '0, 1);
        check_eq("read_33", 32'(r_data), 32'h33);

        phase = "clear";
        for (int i = 0; i < 5; i++) step(0, 0, 1, W'(8'hC0 + i), 0);
        step(0, 1, 1, 8'h77, 1);
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_unf", 32'(underflow), 32'h0);
        step(0, 0, 1, 8'h99, 0);
        step(0, 0, 0, '0, 1);
        check_eq("clr_new_word", 32'(r_data), 32'h99);

        phase = "random";
        for (int blk = 0; blk < 20; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 150; i++) begin
                bit rs, cl, we, re;
                rs = ($urandom_range(0, 299) == 0);
                cl = ($urandom_range(0, 149) == 0);
                we = ($urandom_range(0, 99) < wp);
                re = ($urandom_range(0, 99) < (105 - wp));
                step(rs, cl, we, W'($urandom), re);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_fifo.md
Name: line_fifo

Overview:
- Parametrised synchronous FIFO for pixel/line data between the GPU draw side and the VGA scan-out side, on one clock domain.
- Wraps a simple dual-port RAM and adds:
  - pointer management
  - occupancy count
  - full/empty and programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - synchronous flush
- Read data is registered: one-cycle read latency, qualified by r_valid.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 4, pointer width; depth is 2**ADDR_WIDTH. Only power-of-two depths are supported.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH. Legal range 1..2**ADDR_WIDTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH. Legal range 0..2**ADDR_WIDTH-1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as rst on pointers, count, flags and r_valid. Does not alter RAM contents.
- w_ena  in  1  write request.
- w_data  in  WIDTH  write data.
- r_ena  in  1  read request.
- r_data  out  WIDTH  registered read data.
- r_valid  out  1  one-cycle pulse; r_data holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full with no accepted read.
- underflow  out  1  sticky; a read was attempted while empty.

Behaviour:

Reset (rst=1 at a clock edge):
- w_ptr=0, r_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0.
- Outputs: empty=1, full=0, almost_empty=1, almost_full=0.
- RAM contents are not cleared.

Priority each cycle: rst > clear > read/write.
- clear behaves like reset except r_data holds its value and the RAM is untouched.

Read acceptance:
- rd_acc = r_ena & !empty, evaluated on current-cycle flags.
- On rd_acc: r_data <= mem[r_ptr], r_ptr increments, r_valid=1 next cycle.
- Otherwise r_valid=0 and r_data holds.

Write acceptance:
- wr_acc = w_ena & (!full | rd_acc).
- A write while full is accepted only when a read is accepted in the same cycle.
- On wr_acc: mem[w_ptr] <= w_data, w_ptr increments.

Count update:
- count += wr_acc - rd_acc.
- Simultaneous accepted read and write leaves count unchanged.

Empty with simultaneous write:
- The read is rejected, underflow sets, and the write is accepted; count becomes 1.
- No write-to-read bypass: a word is readable no earlier than the cycle after it is written.

Same-address read/write:
- Only possible when full with rd_acc & wr_acc.
- The read returns the old (oldest) word; the RAM is read-before-write.

Wrap-around:
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Full/empty are decoded from count, not from pointer compare.

Flag timing:
- full, empty, almost_* are combinational decodes of registered count, so they are valid in the cycle after the operation that changed count.

Error flags:
- overflow sets on w_ena & full & !rd_acc.
- underflow sets on r_ena & empty.
- Both stay set until rst or clear.

Decomposition:
- Shared constants include file (fifo_defs), containing:
  - default WIDTH/ADDR_WIDTH for the pixel path
  - default thresholds
  - the depth derivation
- One sub-module, dp_ram:
  - parametrised WIDTH/ADDR_WIDTH
  - one write port with enable and one registered read port with enable
  - no reset
- Pointer, count and flag logic live in line_fifo.

Test Plan:
1. rst=1 for 2 cycles -> count=0, empty=1, full=0, almost_empty=1, r_valid=0, r_data=0, overflow=0, underflow=0.
2. Write 0x01..0x10 (16 words), then 16 reads:
   - after the 16th write: full=1, count=16, almost_full=1 from count=14 onward
   - reads return 0x01..0x10 in order, each with r_valid one cycle after r_ena
   - empty=1 at the end
3. Fill to 16 words, then w_ena=1 (0xAA) with r_ena=0:
   - write dropped, overflow=1, count=16
   - draining returns the original 16 words without 0xAA
4. Full, r_ena=1 and w_ena=1 (0x55) together for 20 cycles:
   - count stays 16
   - reads return 0x01..0x10 then 0x55 x4
   - no overflow, and pointers wrap correctly
5. Empty, r_ena=1 and w_ena=1 (0x33) in the same cycle:
   - underflow=1, r_valid=0, count=1
   - next-cycle read returns 0x33
6. Write 5 words, assert clear with w_ena=1 and r_ena=1:
   - next cycle count=0, empty=1, r_valid=0, flags cleared
   - a subsequent write+read returns the new word, not stale data
